// File: rtl/imem_arbiter_if.sv
// Bundle of the two requester channels and the memory streaming channel.
// The slave modport is the arbiter's view; master is the surrounding fabric
// (fetch stage, loader and memory source) as seen from outside the arbiter.
interface imem_arbiter_if #(
  parameter int unsigned IWIDTH = 32
) ();

  // Requester 0: instruction fetch
  logic              r0_i_syn;
  logic [IWIDTH-1:0] r0_o_instr;
  logic              r0_o_ack;
  logic              r0_o_last;

  // Requester 1: boot loader / debug reader
  logic              r1_i_syn;
  logic [IWIDTH-1:0] r1_o_instr;
  logic              r1_o_ack;
  logic              r1_o_last;

  // Memory streaming source
  logic              m_o_syn;
  logic [IWIDTH-1:0] m_i_instr;
  logic              m_i_ack;
  logic              m_i_last;

  modport slave (
    input  r0_i_syn,
    input  r1_i_syn,
    input  m_i_instr,
    input  m_i_ack,
    input  m_i_last,
    output r0_o_instr,
    output r0_o_ack,
    output r0_o_last,
    output r1_o_instr,
    output r1_o_ack,
    output r1_o_last,
    output m_o_syn
  );

  modport master (
    output r0_i_syn,
    output r1_i_syn,
    output m_i_instr,
    output m_i_ack,
    output m_i_last,
    input  r0_o_instr,
    input  r0_o_ack,
    input  r0_o_last,
    input  r1_o_instr,
    input  r1_o_ack,
    input  r1_o_last,
    input  m_o_syn
  );

endinterface

// File: rtl/imem_arbiter.sv
// Two-requester arbiter for the instruction-memory read port. One requester
// owns the memory for a whole burst; the grant is released on the acked last
// beat or when the owner drops syn, followed by one idle turnaround cycle.
module imem_arbiter #(
  parameter int unsigned IWIDTH     = 32,
  parameter int unsigned FIXED_PRIO = 0,
  parameter int unsigned CWIDTH     = 8
) (
  input  logic              f_clk,
  input  logic              f_rst,
  imem_arbiter_if.slave     bus,
  output logic [1:0]        o_grant,
  output logic              o_busy,
  output logic [CWIDTH-1:0] o_beats
);

  typedef enum logic [1:0] {StIdle, StBusy0, StBusy1} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;     // index of the requester served last
  logic [CWIDTH-1:0] beats_q, beats_d;

  logic [IWIDTH-1:0] mem_data;
  logic              beat_inc;
  logic [CWIDTH-1:0] beats_inc;

  assign mem_data  = bus.m_i_instr;
  // Saturating increment of the beat counter
  assign beats_inc = (beats_q == {CWIDTH{1'b1}}) ? beats_q : beats_q + 1'b1;

  // State, last-served and beat counter registers
  always_ff @(posedge f_clk or negedge f_rst) begin
    if (!f_rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beats_q <= beats_d;
    end
  end

  // Next-state: arbitration in idle, burst end / abandon detection when busy
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    beats_d  = beats_q;
    beat_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.r0_i_syn && bus.r1_i_syn) begin
          // Tie: fixed priority favours r0, otherwise whoever was not served last
          if ((FIXED_PRIO != 0) || last_q) begin
            state_d = StBusy0;
          end else begin
            state_d = StBusy1;
          end
        end else if (bus.r0_i_syn) begin
          state_d = StBusy0;
        end else if (bus.r1_i_syn) begin
          state_d = StBusy1;
        end
        if (state_d != StIdle) begin
          beats_d = '0;
        end
      end
      StBusy0: begin
        beat_inc = bus.m_i_ack;
        if (!bus.r0_i_syn || (bus.m_i_ack && bus.m_i_last)) begin
          state_d = StIdle;
          last_d  = 1'b0;
        end
      end
      StBusy1: begin
        beat_inc = bus.m_i_ack;
        if (!bus.r1_i_syn || (bus.m_i_ack && bus.m_i_last)) begin
          state_d = StIdle;
          last_d  = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (beat_inc) begin
      beats_d = beats_inc;
    end
  end

  // Routing: the granted requester sees memory traffic, the other sees zeros
  always_comb begin
    bus.m_o_syn    = 1'b0;
    bus.r0_o_instr = '0;
    bus.r0_o_ack   = 1'b0;
    bus.r0_o_last  = 1'b0;
    bus.r1_o_instr = '0;
    bus.r1_o_ack   = 1'b0;
    bus.r1_o_last  = 1'b0;
    o_grant        = 2'b00;
    unique case (state_q)
      StBusy0: begin
        bus.m_o_syn    = bus.r0_i_syn;
        bus.r0_o_instr = mem_data;
        bus.r0_o_ack   = bus.m_i_ack;
        bus.r0_o_last  = bus.m_i_last;
        o_grant        = 2'b01;
      end
      StBusy1: begin
        bus.m_o_syn    = bus.r1_i_syn;
        bus.r1_o_instr = mem_data;
        bus.r1_o_ack   = bus.m_i_ack;
        bus.r1_o_last  = bus.m_i_last;
        o_grant        = 2'b10;
      end
      default: begin
        o_grant = 2'b00;
      end
    endcase
  end

  assign o_busy  = (state_q != StIdle);
  assign o_beats = beats_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench: instance A is round-robin with an 8-bit counter, instance B
// is fixed-priority with a 2-bit counter to exercise saturation.
module tb_imem_arbiter;

  logic f_clk;
  logic f_rst;

  int n_tests;
  int n_fail;

  imem_arbiter_if #(.IWIDTH(32)) bus_a ();
  imem_arbiter_if #(.IWIDTH(32)) bus_b ();

  logic [1:0] grant_a, grant_b;
  logic       busy_a, busy_b;
  logic [7:0] beats_a;
  logic [1:0] beats_b;

  imem_arbiter #(
    .IWIDTH    (32),
    .FIXED_PRIO(0),
    .CWIDTH    (8)
  ) u_dut_a (
    .f_clk  (f_clk),
    .f_rst  (f_rst),
    .bus    (bus_a),
    .o_grant(grant_a),
    .o_busy (busy_a),
    .o_beats(beats_a)
  );

  imem_arbiter #(
    .IWIDTH    (32),
    .FIXED_PRIO(1),
    .CWIDTH    (2)
  ) u_dut_b (
    .f_clk  (f_clk),
    .f_rst  (f_rst),
    .bus    (bus_b),
    .o_grant(grant_b),
    .o_busy (busy_b),
    .o_beats(beats_b)
  );

  initial f_clk = 1'b0;
  always #5 f_clk = ~f_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge f_clk);
    #1;
  endtask

  task automatic mem_a(input logic [31:0] d, input logic ack, input logic last);
    bus_a.m_i_instr = d;
    bus_a.m_i_ack   = ack;
    bus_a.m_i_last  = last;
  endtask

  task automatic mem_b(input logic [31:0] d, input logic ack, input logic last);
    bus_b.m_i_instr = d;
    bus_b.m_i_ack   = ack;
    bus_b.m_i_last  = last;
  endtask

  task automatic pulse_reset();
    f_rst = 1'b0;
    #1;
    f_rst = 1'b1;
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    f_rst   = 1'b1;
    bus_a.r0_i_syn = 1'b0;
    bus_a.r1_i_syn = 1'b0;
    bus_b.r0_i_syn = 1'b0;
    bus_b.r1_i_syn = 1'b0;
    mem_a(32'h0, 1'b0, 1'b0);
    mem_b(32'h0, 1'b0, 1'b0);

    // Reset state
    #2 f_rst = 1'b0;
    #1;
    chk("rst_grant", grant_a, 2'b00);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_msyn", bus_a.m_o_syn, 1'b0);
    chk("rst_beats", beats_a, 8'd0);
    chk("rst_r0ack", bus_a.r0_o_ack, 1'b0);
    tick();
    f_rst = 1'b1;

    // 1: r0 alone, 5-beat burst
    bus_a.r0_i_syn = 1'b1;
    #1;
    chk("t1_grant_lat", grant_a, 2'b00);
    tick();
    chk("t1_grant", grant_a, 2'b01);
    chk("t1_msyn", bus_a.m_o_syn, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      mem_a(32'h11 * i, 1'b1, (i == 5));
      #1;
      chk("t1_r0instr", bus_a.r0_o_instr, 32'h11 * i);
      chk("t1_r0ack", bus_a.r0_o_ack, 1'b1);
      chk("t1_r1ack", bus_a.r1_o_ack, 1'b0);
      tick();
    end
    bus_a.r0_i_syn = 1'b0;
    mem_a(32'h0, 1'b0, 1'b0);
    #1;
    chk("t1_idle_grant", grant_a, 2'b00);
    chk("t1_idle_msyn", bus_a.m_o_syn, 1'b0);
    chk("t1_beats", beats_a, 8'd5);
    tick();
    chk("t1_beats_hold", beats_a, 8'd5);

    // 2: round-robin with both pending
    pulse_reset();
    bus_a.r0_i_syn = 1'b1;
    bus_a.r1_i_syn = 1'b1;
    tick();
    chk("t2_g0", grant_a, 2'b01);
    mem_a(32'hA0, 1'b1, 1'b1);
    #1;
    chk("t2_r0instr", bus_a.r0_o_instr, 32'hA0);
    chk("t2_r1instr", bus_a.r1_o_instr, 32'h0);
    tick();
    mem_a(32'h0, 1'b0, 1'b0);
    #1;
    chk("t2_turn1", grant_a, 2'b00);
    chk("t2_turn1_msyn", bus_a.m_o_syn, 1'b0);
    tick();
    chk("t2_g1", grant_a, 2'b10);
    mem_a(32'hB0, 1'b1, 1'b1);
    #1;
    chk("t2_r1instr_b", bus_a.r1_o_instr, 32'hB0);
    chk("t2_r1last", bus_a.r1_o_last, 1'b1);
    chk("t2_r0ack_b", bus_a.r0_o_ack, 1'b0);
    tick();
    mem_a(32'h0, 1'b0, 1'b0);
    #1;
    chk("t2_turn2", grant_a, 2'b00);
    tick();
    chk("t2_g2", grant_a, 2'b01);
    bus_a.r0_i_syn = 1'b0;
    bus_a.r1_i_syn = 1'b0;
    tick();
    chk("t2_end", grant_a, 2'b00);

    // 4: r1 abandons after 2 beats while r0 waits
    bus_a.r1_i_syn = 1'b1;
    tick();
    chk("t4_g1", grant_a, 2'b10);
    bus_a.r0_i_syn = 1'b1;
    for (int i = 1; i <= 2; i++) begin
      mem_a(32'hC0 + i, 1'b1, 1'b0);
      tick();
      chk("t4_nopreempt", grant_a, 2'b10);
    end
    mem_a(32'h0, 1'b0, 1'b0);
    bus_a.r1_i_syn = 1'b0;
    #1;
    chk("t4_msyn_drop", bus_a.m_o_syn, 1'b0);
    tick();
    chk("t4_idle", grant_a, 2'b00);
    chk("t4_beats", beats_a, 8'd2);
    tick();
    chk("t4_g0", grant_a, 2'b01);
    chk("t4_beats_clr", beats_a, 8'd0);
    bus_a.r0_i_syn = 1'b0;
    tick();

    // 5: async reset on beat 3, then a stray beat in idle
    bus_a.r0_i_syn = 1'b1;
    tick();
    for (int i = 1; i <= 2; i++) begin
      mem_a(32'hD0 + i, 1'b1, 1'b0);
      tick();
    end
    chk("t5_beats2", beats_a, 8'd2);
    mem_a(32'hD3, 1'b1, 1'b0);
    #1;
    f_rst = 1'b0;
    #1;
    chk("t5_grant", grant_a, 2'b00);
    chk("t5_msyn", bus_a.m_o_syn, 1'b0);
    chk("t5_beats", beats_a, 8'd0);
    chk("t5_r0ack", bus_a.r0_o_ack, 1'b0);
    bus_a.r0_i_syn = 1'b0;
    tick();
    f_rst = 1'b1;
    mem_a(32'hEE, 1'b1, 1'b1);
    #1;
    chk("t5_stray_r0", bus_a.r0_o_ack, 1'b0);
    chk("t5_stray_r1", bus_a.r1_o_ack, 1'b0);
    tick();
    mem_a(32'h0, 1'b0, 1'b0);
    chk("t5_stray_beats", beats_a, 8'd0);
    chk("t5_stray_grant", grant_a, 2'b00);

    // 3 + 6: fixed priority and counter saturation on instance B
    bus_b.r0_i_syn = 1'b1;
    bus_b.r1_i_syn = 1'b1;
    tick();
    chk("t3_g0", grant_b, 2'b01);
    for (int i = 1; i <= 6; i++) begin
      mem_b(32'h100 + i, 1'b1, (i == 6));
      tick();
      chk("t6_beats", beats_b, (i > 3) ? 2'd3 : i[1:0]);
    end
    mem_b(32'h0, 1'b0, 1'b0);
    chk("t3_turn", grant_b, 2'b00);
    tick();
    chk("t3_g0_again", grant_b, 2'b01);
    mem_b(32'h200, 1'b1, 1'b1);
    tick();
    mem_b(32'h0, 1'b0, 1'b0);
    tick();
    chk("t3_g0_third", grant_b, 2'b01);
    chk("t3_r1ack", bus_b.r1_o_ack, 1'b0);
    bus_b.r0_i_syn = 1'b0;
    tick();
    chk("t3_abandon", grant_b, 2'b00);
    tick();
    chk("t3_g1_alone", grant_b, 2'b10);
    bus_b.r1_i_syn = 1'b0;
    tick();
    chk("t3_end", busy_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case the sequence above ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Two-requester arbiter for the single instruction-memory read port (the syn/ack/last burst streaming source).
- Requester 0 is the instruction-fetch stage; requester 1 is the boot loader / debug reader.
- Grants one requester per burst and holds the grant until the burst's last beat is acked. Routes memory data, ack and last only to the granted requester.
- Sits between the fetch stage, the loader and the memory streaming source.

Parameters:
- IWIDTH, 32, instruction/data word width.
- FIXED_PRIO, 0; 0 = round-robin between requesters, 1 = requester 0 always wins a tie.
- CWIDTH, 8, width of the beat counter status output.

Ports:
- f_clk  input  1  clock, rising edge
- f_rst  input  1  reset, asynchronous, active-low
- r0_i_syn  input  1  requester 0 burst request, held high while it wants beats
- r0_o_instr  output  IWIDTH  data to requester 0
- r0_o_ack  output  1  beat valid for requester 0
- r0_o_last  output  1  final beat of burst for requester 0
- r1_i_syn  input  1  requester 1 burst request
- r1_o_instr  output  IWIDTH  data to requester 1
- r1_o_ack  output  1  beat valid for requester 1
- r1_o_last  output  1  final beat for requester 1
- m_o_syn  output  1  request to memory source
- m_i_instr  input  IWIDTH  memory data
- m_i_ack  input  1  memory beat valid
- m_i_last  input  1  memory final beat
- o_grant  output  2  one-hot current grant; 00 when idle
- o_busy  output  1  a burst is in progress
- o_beats  output  CWIDTH  acked beats in the current burst, saturating at all-ones

Behaviour:
- Reset (f_rst low, async):
  - State IDLE.
  - All outputs 0: m_o_syn, o_grant, o_busy, o_beats, and every r*_o_* signal.
  - last_served = 1, so requester 0 wins the first tie.
- FSM states: IDLE, BUSY0, BUSY1. State, last_served and o_beats are registered. Routing outputs are combinational from state.
- IDLE:
  - Only r0_i_syn high -> BUSY0.
  - Only r1_i_syn high -> BUSY1.
  - Both high: FIXED_PRIO=1 -> BUSY0; FIXED_PRIO=0 -> the requester not equal to last_served.
  - Neither high -> stay in IDLE.
  - Grant latency: syn sampled high at edge N gives BUSYx and m_o_syn high during cycle N+1.
- BUSYx:
  - m_o_syn = rx_i_syn.
  - rx_o_instr = m_i_instr, rx_o_ack = m_i_ack, rx_o_last = m_i_last.
  - The non-granted requester sees instr, ack and last all 0.
  - o_grant[x] = 1; o_busy = 1.
- Burst end: m_i_ack && m_i_last in BUSYx -> IDLE at the next edge, and last_served <= x.
  - There is one mandatory IDLE turnaround cycle; m_o_syn is 0 during it.
- Abandon: rx_i_syn low in BUSYx -> IDLE at the next edge, and last_served <= x.
  - A beat acked in that same cycle is still forwarded to rx.
- A beat arriving in IDLE (stray m_i_ack) is dropped: not forwarded, not counted.
- Beat counter:
  - Cleared to 0 on the IDLE->BUSY transition.
  - Incremented on each m_i_ack in BUSYx; saturates at 2^CWIDTH-1.
  - Holds its value in IDLE until the next grant.
- No pre-emption: the non-granted requester's syn is ignored until IDLE. The granted requester is never switched mid-burst.
- Syn is level-sensitive. A requester keeping syn high across the burst end re-arbitrates in IDLE; under round-robin the other requester wins if it is also pending.
- Async reset mid-burst: returns to IDLE immediately, m_o_syn drops in the same cycle, and o_beats = 0.

Test Plan:
- Reset then r0_i_syn=1 only, memory 5-beat burst 0x11..0x55 with last on beat 5 -> o_grant=01 one cycle after syn; r0 receives all 5 words with ack; r1_o_ack stays 0; o_beats=5; IDLE for one cycle after last.
- Both syn high at the same edge after reset, FIXED_PRIO=0 -> r0 granted first. After its last beat, r1 is granted following the one-cycle turnaround. r0 re-requesting continuously alternates with r1 (01, 00, 10, 00, 01).
- Same as above with FIXED_PRIO=1 and r0 re-requesting -> r0 granted every burst; r1 never granted while r0 pending.
- r1 granted, r1_i_syn dropped after 2 acked beats, no last -> m_o_syn falls the same cycle; IDLE next edge; o_beats=2; pending r0 then granted.
- Async reset asserted on beat 3 of an r0 burst -> o_grant=00, m_o_syn=0, o_beats=0 immediately. After release, stray m_i_ack in IDLE -> not forwarded, o_beats stays 0.
- CWIDTH=2 with a 6-beat burst -> o_beats saturates at 3.
